// File: rtl/l2_msg_issue_arbiter.sv
// l2_msg_issue_arbiter
//   Shares the single L2 pipeline issue slot between the NoC1 request stream (msg1)
//   and the NoC3 memory-response stream (msg3). NoC3 has fixed priority; a starvation
//   counter forces a msg1 grant after STARVE_MAX consecutive msg3 wins over a waiting
//   msg1. The winner is registered into a one-entry issue register, and the number of
//   issued-but-uncommitted messages is capped at MAX_INFLIGHT.
//   Optional feature macro: L2_ARB_STATS_EN (per-stream accepted-message counters).
//   Without it the stat ports are tied to zero and no counter flops are built.
module l2_msg_issue_arbiter #(
    parameter int DATA_W       = 64,
    parameter int TAG_W        = 26,
    parameter int SRC_W        = 6,
    parameter int TYPE_W       = 8,
    parameter int STARVE_MAX   = 4,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic              clk,
    input  logic              rst,
    // NoC1 request stream
    input  logic              msg1_valid,
    output logic              msg1_ready,
    input  logic [TYPE_W-1:0] msg1_type,
    input  logic [SRC_W-1:0]  msg1_source,
    input  logic [TAG_W-1:0]  msg1_tag,
    input  logic [DATA_W-1:0] msg1_data,
    // NoC3 response stream
    input  logic              msg3_valid,
    output logic              msg3_ready,
    input  logic [TYPE_W-1:0] msg3_type,
    input  logic [SRC_W-1:0]  msg3_source,
    input  logic [TAG_W-1:0]  msg3_tag,
    input  logic [DATA_W-1:0] msg3_data,
    // issue register towards pipeline S1
    output logic              iss_valid,
    input  logic              iss_ready,
    output logic              iss_sel,
    output logic [TYPE_W-1:0] iss_type,
    output logic [SRC_W-1:0]  iss_source,
    output logic [TAG_W-1:0]  iss_tag,
    output logic [DATA_W-1:0] iss_data,
    // in-flight accounting
    input  logic              commit,
    output logic [3:0]        inflight,
    output logic              err_underflow,
    // statistics
    output logic [15:0]       stat_msg1_grants,
    output logic [15:0]       stat_msg3_grants
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // issue register empty
        ST_HOLD = 2'd1,   // issue register holds a message
        ST_FULL = 2'd2    // register empty, credit exhausted
    } state_t;

    state_t              state_q, state_d;
    logic                iss_sel_q, iss_sel_d;
    logic [TYPE_W-1:0]   iss_type_q, iss_type_d;
    logic [SRC_W-1:0]    iss_source_q, iss_source_d;
    logic [TAG_W-1:0]    iss_tag_q, iss_tag_d;
    logic [DATA_W-1:0]   iss_data_q, iss_data_d;
    logic [3:0]          inflight_q, inflight_d;
    logic                err_underflow_q, err_underflow_d;
    logic [3:0]          starve_cnt_q, starve_cnt_d;

    logic                issue;
    logic                commit_eff;
    logic [4:0]          inflight_next_base;
    logic                slot_free;
    logic                load_allowed;
    logic                starved;
    logic                grant1;
    logic                grant3;
    logic                load;

    // Arbitration, credit check, and next-state for issue register, counters and FSM.
    // NOTE: every signal assigned here gets a default first so no latch can be inferred.
    always_comb begin
        state_d         = state_q;
        iss_sel_d       = iss_sel_q;
        iss_type_d      = iss_type_q;
        iss_source_d    = iss_source_q;
        iss_tag_d       = iss_tag_q;
        iss_data_d      = iss_data_q;
        err_underflow_d = err_underflow_q;
        starve_cnt_d    = starve_cnt_q;

        issue      = (state_q == ST_HOLD) && iss_ready;
        // A commit with nothing in flight is an error, not a decrement.
        commit_eff = commit && (inflight_q != 4'd0);

        // Credit seen by a message loaded now: current count plus the one leaving the
        // register this cycle, minus this cycle's retirement.
        inflight_next_base = 5'(inflight_q) + 5'(issue) - 5'(commit_eff);
        inflight_d         = inflight_next_base[3:0];

        slot_free    = (state_q != ST_HOLD) || iss_ready;
        load_allowed = slot_free && (inflight_next_base < 5'(MAX_INFLIGHT));

        starved = msg1_valid && (starve_cnt_q == 4'(STARVE_MAX));
        grant3  = msg3_valid && !starved;
        grant1  = msg1_valid && !grant3;

        // Readies are forced low during the reset cycle.
        msg1_ready = !rst && load_allowed && grant1;
        msg3_ready = !rst && load_allowed && grant3;
        load       = msg1_ready || msg3_ready;

        if (load) begin
            iss_sel_d = msg3_ready;
            if (msg3_ready) begin
                iss_type_d   = msg3_type;
                iss_source_d = msg3_source;
                iss_tag_d    = msg3_tag;
                iss_data_d   = msg3_data;
            end else begin
                iss_type_d   = msg1_type;
                iss_source_d = msg1_source;
                iss_tag_d    = msg1_tag;
                iss_data_d   = msg1_data;
            end
        end

        if (commit && (inflight_q == 4'd0)) begin
            err_underflow_d = 1'b1;
        end

        if (!msg1_valid || msg1_ready) begin
            starve_cnt_d = 4'd0;
        end else if (msg3_ready && (starve_cnt_q < 4'(STARVE_MAX))) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end

        // The register is occupied after a load or while a held message is not taken.
        if (load || ((state_q == ST_HOLD) && !iss_ready)) begin
            state_d = ST_HOLD;
        end else if (inflight_d == 4'(MAX_INFLIGHT)) begin
            state_d = ST_FULL;
        end else begin
            state_d = ST_IDLE;
        end
    end

    // State register with synchronous reset; a held message is dropped on reset.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            iss_sel_q       <= 1'b0;
            iss_type_q      <= '0;
            iss_source_q    <= '0;
            iss_tag_q       <= '0;
            iss_data_q      <= '0;
            inflight_q      <= 4'd0;
            err_underflow_q <= 1'b0;
            starve_cnt_q    <= 4'd0;
        end else begin
            state_q         <= state_d;
            iss_sel_q       <= iss_sel_d;
            iss_type_q      <= iss_type_d;
            iss_source_q    <= iss_source_d;
            iss_tag_q       <= iss_tag_d;
            iss_data_q      <= iss_data_d;
            inflight_q      <= inflight_d;
            err_underflow_q <= err_underflow_d;
            starve_cnt_q    <= starve_cnt_d;
        end
    end

    assign iss_valid     = (state_q == ST_HOLD);
    assign iss_sel       = iss_sel_q;
    assign iss_type      = iss_type_q;
    assign iss_source    = iss_source_q;
    assign iss_tag       = iss_tag_q;
    assign iss_data      = iss_data_q;
    assign inflight      = inflight_q;
    assign err_underflow = err_underflow_q;

`ifdef L2_ARB_STATS_EN
    logic [15:0] stat1_q, stat1_d;
    logic [15:0] stat3_q, stat3_d;

    // Saturating per-stream accepted-message counters.
    always_comb begin
        stat1_d = stat1_q;
        stat3_d = stat3_q;
        if (msg1_ready && (stat1_q != 16'hFFFF)) stat1_d = stat1_q + 16'd1;
        if (msg3_ready && (stat3_q != 16'hFFFF)) stat3_d = stat3_q + 16'd1;
    end

    // Statistic counter registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat1_q <= 16'd0;
            stat3_q <= 16'd0;
        end else begin
            stat1_q <= stat1_d;
            stat3_q <= stat3_d;
        end
    end

    assign stat_msg1_grants = stat1_q;
    assign stat_msg3_grants = stat3_q;
`else
    assign stat_msg1_grants = 16'h0;
    assign stat_msg3_grants = 16'h0;
`endif

endmodule
